// File: rtl/osd_regaccess_initiator.sv
// -----------------------------------------------------------------------------
// osd_regaccess_initiator
//
// Issues a single 16-bit register read or write over the debug interconnect
// (DII) and waits for the matching response packet.
//
// A request is accepted in IDLE. It is serialised as dest, src, type, addr and,
// for writes, wdata, one flit per handshake. The block then watches debug_in
// for a response addressed to `id` and sent from the requested destination.
// Non-matching packets are drained. A timeout closes the transaction if no
// valid reply arrives.
//
// Ports
//   clk, rst             : clock, asynchronous active-low reset
//   id                   : own DII address (request source, response target)
//   req_*                : register access request (valid/ready)
//   resp_*               : one-cycle completion report
//   debug_out(_ready)    : outgoing DII flits with back-pressure
//   debug_in(_ready)     : incoming DII flits, never back-pressured
// -----------------------------------------------------------------------------
package osd_dii_pkg;
    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        valid;
    } dii_flit;
endpackage

module osd_regaccess_initiator
    import osd_dii_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  id,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_dest,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic        resp_timeout,
    output dii_flit     debug_out,
    input  logic        debug_out_ready,
    input  dii_flit     debug_in,
    output logic        debug_in_ready
);

    localparam int              CW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [5:0] REQ_READ16          = 6'h08;
    localparam logic [5:0] REQ_WRITE16         = 6'h0A;
    localparam logic [5:0] RESP_READ_SUCCESS16 = 6'h0C;
    localparam logic [5:0] RESP_READ_ERROR     = 6'h0D;
    localparam logic [5:0] RESP_WRITE_SUCCESS  = 6'h0E;
    localparam logic [5:0] RESP_WRITE_ERROR    = 6'h0F;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        TX_DEST  = 4'd1,
        TX_SRC   = 4'd2,
        TX_TYPE  = 4'd3,
        TX_ADDR  = 4'd4,
        TX_WDATA = 4'd5,
        RX_DEST  = 4'd6,
        RX_SRC   = 4'd7,
        RX_TYPE  = 4'd8,
        RX_DATA  = 4'd9,
        RX_DRAIN = 4'd10,
        DONE     = 4'd11
    } state_t;

    state_t          state_q, state_d;
    logic            write_q, write_d;
    logic [15:0]     dest_q, dest_d;
    logic [15:0]     addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mid_q, mid_d;          // an incoming packet is in progress
    dii_flit         out_q, out_d;
    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic [15:0]     resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;
    logic            resp_timeout_q, resp_timeout_d;
    logic            in_ready_q, in_ready_d;

    logic            tx_hs;
    logic            rx_active;
    logic            rx_expired;
    logic [5:0]      rx_code;
    state_t          rx_entry;
    logic [15:0]     done_rdata;
    logic            done_err;
    logic            done_tmo;

    // Builds the outgoing flit that belongs to a given TX state.
    function automatic dii_flit build_flit(input state_t st, input logic wr,
                                           input logic [15:0] dest, input logic [15:0] src,
                                           input logic [15:0] addr, input logic [15:0] wdata);
        dii_flit f;
        f = '0;
        case (st)
            TX_DEST:  begin f.data = dest;  f.valid = 1'b1; end
            TX_SRC:   begin f.data = src;   f.valid = 1'b1; end
            TX_TYPE:  begin f.data = {(wr ? REQ_WRITE16 : REQ_READ16), 10'b0}; f.valid = 1'b1; end
            TX_ADDR:  begin f.data = addr;  f.valid = 1'b1; f.last = ~wr; end
            TX_WDATA: begin f.data = wdata; f.valid = 1'b1; f.last = 1'b1; end
            default:  f = '0;
        endcase
        return f;
    endfunction

    assign tx_hs      = out_q.valid & debug_out_ready;
    assign rx_active  = (state_q == RX_DEST) || (state_q == RX_SRC) || (state_q == RX_TYPE) ||
                        (state_q == RX_DATA) || (state_q == RX_DRAIN);
    assign rx_expired = rx_active && (cnt_q == CNT_LAST);
    assign rx_code    = debug_in.data[15:10];

    // Next-state, capture, timeout and registered-output computation.
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        dest_d     = dest_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        done_rdata = 16'h0000;
        done_err   = 1'b0;
        done_tmo   = 1'b0;

        // Packet boundaries are tracked in every state so that a packet
        // already in flight when RX starts is dropped up to its last flit.
        if (debug_in.valid) begin
            mid_d = ~debug_in.last;
        end else begin
            mid_d = mid_q;
        end
        rx_entry = mid_d ? RX_DRAIN : RX_DEST;

        if (rx_active) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (rx_expired) begin
            // Expiry wins over any flit seen in the same cycle.
            state_d  = DONE;
            done_err = 1'b1;
            done_tmo = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        write_d = req_write;
                        dest_d  = req_dest;
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        state_d = TX_DEST;
                    end else begin
                        state_d = IDLE;
                    end
                end
                TX_DEST:  state_d = tx_hs ? TX_SRC  : TX_DEST;
                TX_SRC:   state_d = tx_hs ? TX_TYPE : TX_SRC;
                TX_TYPE:  state_d = tx_hs ? TX_ADDR : TX_TYPE;
                TX_ADDR: begin
                    if (tx_hs) begin
                        if (write_q) begin
                            state_d = TX_WDATA;
                        end else begin
                            state_d = rx_entry;
                            cnt_d   = '0;
                        end
                    end else begin
                        state_d = TX_ADDR;
                    end
                end
                TX_WDATA: begin
                    if (tx_hs) begin
                        state_d = rx_entry;
                        cnt_d   = '0;
                    end else begin
                        state_d = TX_WDATA;
                    end
                end
                RX_DEST: begin
                    if (debug_in.valid) begin
                        if ((debug_in.data[9:0] == id) && !debug_in.last) begin
                            state_d = RX_SRC;
                        end else if (debug_in.last) begin
                            state_d = RX_DEST;
                        end else begin
                            state_d = RX_DRAIN;
                        end
                    end else begin
                        state_d = RX_DEST;
                    end
                end
                RX_SRC: begin
                    if (debug_in.valid) begin
                        if ((debug_in.data == dest_q) && !debug_in.last) begin
                            state_d = RX_TYPE;
                        end else if (debug_in.last) begin
                            state_d = RX_DEST;
                        end else begin
                            state_d = RX_DRAIN;
                        end
                    end else begin
                        state_d = RX_SRC;
                    end
                end
                RX_TYPE: begin
                    if (debug_in.valid) begin
                        if (!write_q && (rx_code == RESP_READ_SUCCESS16) && !debug_in.last) begin
                            state_d = RX_DATA;
                        end else if (!write_q && (rx_code == RESP_READ_ERROR) && debug_in.last) begin
                            state_d  = DONE;
                            done_err = 1'b1;
                        end else if (write_q && (rx_code == RESP_WRITE_SUCCESS) && debug_in.last) begin
                            state_d = DONE;
                        end else if (write_q && (rx_code == RESP_WRITE_ERROR) && debug_in.last) begin
                            state_d  = DONE;
                            done_err = 1'b1;
                        end else if (debug_in.last) begin
                            state_d = RX_DEST;
                        end else begin
                            state_d = RX_DRAIN;
                        end
                    end else begin
                        state_d = RX_TYPE;
                    end
                end
                RX_DATA: begin
                    if (debug_in.valid) begin
                        if (debug_in.last) begin
                            state_d    = DONE;
                            done_rdata = debug_in.data;
                        end else begin
                            // Read success carries exactly one data flit.
                            state_d = RX_DRAIN;
                        end
                    end else begin
                        state_d = RX_DATA;
                    end
                end
                RX_DRAIN: begin
                    if (debug_in.valid && debug_in.last) begin
                        state_d = RX_DEST;
                    end else begin
                        state_d = RX_DRAIN;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        resp_valid_d = (state_d == DONE);
        if (state_d == DONE) begin
            resp_rdata_d   = done_rdata;
            resp_err_d     = done_err;
            resp_timeout_d = done_tmo;
        end else begin
            resp_rdata_d   = resp_rdata_q;
            resp_err_d     = resp_err_q;
            resp_timeout_d = resp_timeout_q;
        end

        out_d       = build_flit(state_d, write_d, dest_d, {6'b000000, id}, addr_d, wdata_d);
        req_ready_d = (state_d == IDLE);
        in_ready_d  = 1'b1;
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            write_q        <= 1'b0;
            dest_q         <= 16'h0000;
            addr_q         <= 16'h0000;
            wdata_q        <= 16'h0000;
            cnt_q          <= '0;
            mid_q          <= 1'b0;
            out_q          <= '0;
            req_ready_q    <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= 16'h0000;
            resp_err_q     <= 1'b0;
            resp_timeout_q <= 1'b0;
            in_ready_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            write_q        <= write_d;
            dest_q         <= dest_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            cnt_q          <= cnt_d;
            mid_q          <= mid_d;
            out_q          <= out_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_err_q     <= resp_err_d;
            resp_timeout_q <= resp_timeout_d;
            in_ready_q     <= in_ready_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign resp_timeout   = resp_timeout_q;
    assign debug_out      = out_q;
    assign debug_in_ready = in_ready_q;

endmodule
